// File: rtl/reg_wb_arbiter_if.sv
// Writeback request, register-file write/carry port and scoreboard signals shared by
// the ALU/load requesters, decode and the reg_wb_arbiter.
interface reg_wb_arbiter_if #(
  parameter int num_regs  = 13,
  parameter int reg_width = 8
);
  localparam int aw = $clog2(num_regs);

  logic                 a_valid;
  logic                 a_ready;
  logic [aw-1:0]        a_addr;
  logic [reg_width-1:0] a_data;
  logic                 a_clear;
  logic                 a_car_we;
  logic [reg_width-1:0] a_car;

  logic                 m_valid;
  logic                 m_ready;
  logic [aw-1:0]        m_addr;
  logic [reg_width-1:0] m_data;

  logic                 res_valid;
  logic [aw-1:0]        res_addr;

  logic                 reg_write;
  logic                 reg_clear;
  logic [aw-1:0]        rd_addr;
  logic [reg_width-1:0] rd_in;
  logic                 car_write;
  logic [reg_width-1:0] car_in;
  logic [num_regs-1:0]  busy_mask;
  logic                 addr_err;

  modport slave (
    input  a_valid, a_addr, a_data, a_clear, a_car_we, a_car,
    input  m_valid, m_addr, m_data,
    input  res_valid, res_addr,
    output a_ready, m_ready,
    output reg_write, reg_clear, rd_addr, rd_in, car_write, car_in,
    output busy_mask, addr_err
  );

  modport master (
    output a_valid, a_addr, a_data, a_clear, a_car_we, a_car,
    output m_valid, m_addr, m_data,
    output res_valid, res_addr,
    input  a_ready, m_ready,
    input  reg_write, reg_clear, rd_addr, rd_in, car_write, car_in,
    input  busy_mask, addr_err
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the register-file write/carry port between ALU and load writeback,
// with registered outputs (one cycle after transfer) and a per-register pending-write scoreboard.
module reg_wb_arbiter #(
  parameter int num_regs  = 13,
  parameter int reg_width = 8
) (
  input  logic             clk,
  input  logic             rst,
  reg_wb_arbiter_if.slave  bus
);
  localparam int            aw      = $clog2(num_regs);
  localparam int            car_idx = num_regs - 1;
  localparam logic [aw:0]   n_regs  = num_regs[aw:0];

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

  grant_e               last_grant_q, last_grant_d;
  logic                 reg_write_q, reg_write_d;
  logic                 reg_clear_q, reg_clear_d;
  logic [aw-1:0]        rd_addr_q, rd_addr_d;
  logic [reg_width-1:0] rd_in_q, rd_in_d;
  logic                 car_write_q, car_write_d;
  logic [reg_width-1:0] car_in_q, car_in_d;
  logic                 addr_err_q, addr_err_d;
  logic [num_regs-1:0]  busy_q, busy_d;

  logic          grant_a, grant_m;
  logic [aw-1:0] sel_addr;
  logic          sel_ok, sel_nz, res_ok;

  // Both requesting: the side that did not win last time gets the port.
  always_comb begin
    grant_a  = bus.a_valid && (!bus.m_valid || (last_grant_q == GRANT_MEM));
    grant_m  = bus.m_valid && !grant_a;
    sel_addr = grant_a ? bus.a_addr : bus.m_addr;
    sel_ok   = ({1'b0, sel_addr} < n_regs);
    sel_nz   = (sel_addr != '0);
    res_ok   = bus.res_valid && ({1'b0, bus.res_addr} < n_regs) && (bus.res_addr != '0);
  end

  assign bus.a_ready = grant_a;
  assign bus.m_ready = grant_m;

  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    reg_clear_d  = 1'b0;
    car_write_d  = 1'b0;
    addr_err_d   = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_in_d      = rd_in_q;
    car_in_d     = car_in_q;
    busy_d       = busy_q;

    if (grant_a || grant_m) begin
      last_grant_d = grant_a ? GRANT_ALU : GRANT_MEM;
      rd_addr_d    = sel_addr;
      reg_write_d  = sel_ok && sel_nz;
      addr_err_d   = !sel_ok;
      if (sel_ok) begin
        busy_d[sel_addr] = 1'b0;
      end
    end

    if (grant_a) begin
      reg_clear_d = bus.a_clear && sel_ok && sel_nz;
      rd_in_d     = bus.a_clear ? '0 : bus.a_data;
      car_write_d = bus.a_car_we;
      if (bus.a_car_we) begin
        car_in_d        = bus.a_car;
        busy_d[car_idx] = 1'b0;
      end
    end else if (grant_m) begin
      rd_in_d = bus.m_data;
    end

    // Applied after release so a same-cycle reserve of the same register wins.
    if (res_ok) begin
      busy_d[bus.res_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_MEM;
      reg_write_q  <= 1'b0;
      reg_clear_q  <= 1'b0;
      rd_addr_q    <= '0;
      rd_in_q      <= '0;
      car_write_q  <= 1'b0;
      car_in_q     <= '0;
      addr_err_q   <= 1'b0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      reg_clear_q  <= reg_clear_d;
      rd_addr_q    <= rd_addr_d;
      rd_in_q      <= rd_in_d;
      car_write_q  <= car_write_d;
      car_in_q     <= car_in_d;
      addr_err_q   <= addr_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.reg_write = reg_write_q;
  assign bus.reg_clear = reg_clear_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_in     = rd_in_q;
  assign bus.car_write = car_write_q;
  assign bus.car_in    = car_in_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.busy_mask = busy_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus random traffic, checked by a
// reference model feeding an expectation queue that a separate monitor drains.
module tb_reg_wb_arbiter;
  localparam int N = 13;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_wb_arbiter_if #(.num_regs(N), .reg_width(W)) bus ();

  reg_wb_arbiter #(.num_regs(N), .reg_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic         rc;
    logic [3:0]   ra;
    logic [W-1:0] rd;
    logic         cw;
    logic [W-1:0] ci;
    logic         ae;
    logic [N-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state
  bit   last_was_mem = 1'b1;
  bit   mbusy[N];
  bit   a_done = 1'b0;
  bit   m_done = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.a_valid   = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.a_clear   = 1'b0; bus.a_car_we = 1'b0; bus.a_car = '0;
    bus.m_valid   = 1'b0; bus.m_addr = '0; bus.m_data = '0;
    bus.res_valid = 1'b0; bus.res_addr = '0;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] ad, input logic [W-1:0] d,
                         input logic clr, input logic cwe, input logic [W-1:0] c);
    bus.a_valid = v; bus.a_addr = ad; bus.a_data = d;
    bus.a_clear = clr; bus.a_car_we = cwe; bus.a_car = c;
  endtask

  task automatic drive_m(input logic v, input logic [3:0] ad, input logic [W-1:0] d);
    bus.m_valid = v; bus.m_addr = ad; bus.m_data = d;
  endtask

  task automatic drive_res(input logic v, input logic [3:0] ad);
    bus.res_valid = v; bus.res_addr = ad;
  endtask

  function automatic logic [3:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 4'd0;
    if (r == 1) return 4'($urandom_range(N, 15));
    return 4'($urandom_range(1, N - 1));
  endfunction

  // Requesters hold their fields until the model says they were taken.
  task automatic rand_cycle();
    if (!bus.a_valid || a_done) begin
      drive_a(($urandom_range(0, 2) != 0), rand_addr(), W'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), W'($urandom));
    end
    if (!bus.m_valid || m_done) begin
      drive_m(($urandom_range(0, 2) != 0), rand_addr(), W'($urandom));
    end
    drive_res(($urandom_range(0, 2) == 0), rand_addr());
    step();
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (bus.reg_write !== 1'b0 || bus.reg_clear !== 1'b0 || bus.rd_addr !== '0 ||
        bus.rd_in !== '0 || bus.car_write !== 1'b0 || bus.car_in !== '0 ||
        bus.addr_err !== 1'b0 || bus.busy_mask !== '0) begin
      n_fail++;
      $display("FAIL %s: got rw=%b rc=%b ra=%0d rd=%h cw=%b ci=%h ae=%b busy=%h, want all zero",
               name, bus.reg_write, bus.reg_clear, bus.rd_addr, bus.rd_in,
               bus.car_write, bus.car_in, bus.addr_err, bus.busy_mask);
    end
  endtask

  // Reference model: decides the grant from the round-robin rule, checks readies,
  // and predicts next cycle's register-file outputs and pending set.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_was_mem = 1'b1;
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      a_done = 1'b0;
      m_done = 1'b0;
    end else begin
      exp_t e;
      bit   take_a, take_m;
      int   ad;
      logic [N-1:0] bv;
      if (bus.a_valid && bus.m_valid) begin
        take_a = last_was_mem;
        take_m = !last_was_mem;
      end else begin
        take_a = bus.a_valid;
        take_m = bus.m_valid;
      end
      n_tests++;
      if (bus.a_ready !== take_a || bus.m_ready !== take_m) begin
        n_fail++;
        $display("FAIL ready cyc=%0d: got a_ready=%b m_ready=%b, want %b %b",
                 cyc, bus.a_ready, bus.m_ready, take_a, take_m);
      end
      e = '{rw: 1'b0, rc: 1'b0, ra: '0, rd: '0, cw: 1'b0, ci: '0, ae: 1'b0, busy: '0};
      if (take_a || take_m) begin
        ad   = take_a ? int'(bus.a_addr) : int'(bus.m_addr);
        e.ra = 4'(ad);
        e.ae = (ad >= N);
        e.rw = (ad != 0) && (ad < N);
        if (ad < N) mbusy[ad] = 1'b0;
        last_was_mem = take_m;
      end
      if (take_a) begin
        e.rc = bus.a_clear && e.rw;
        e.rd = bus.a_clear ? '0 : bus.a_data;
        e.cw = bus.a_car_we;
        e.ci = bus.a_car;
        if (bus.a_car_we) mbusy[N-1] = 1'b0;
      end else if (take_m) begin
        e.rd = bus.m_data;
      end
      if (bus.res_valid && bus.res_addr != 0 && int'(bus.res_addr) < N)
        mbusy[int'(bus.res_addr)] = 1'b1;
      for (int i = 0; i < N; i++) bv[i] = mbusy[i];
      e.busy = bv;
      exp_q.push_back(e);
      a_done = take_a;
      m_done = take_m;
    end
  end

  // Monitor: compares the registered outputs after each edge with the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst && exp_q.size() > 0) begin
        exp_t e;
        bit   ok;
        e  = exp_q.pop_front();
        ok = (bus.reg_write === e.rw) && (bus.reg_clear === e.rc) &&
             (bus.car_write === e.cw) && (bus.addr_err === e.ae) &&
             (bus.busy_mask === e.busy) &&
             (!e.rw || (bus.rd_addr === e.ra && bus.rd_in === e.rd)) &&
             (!e.cw || bus.car_in === e.ci);
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL out cyc=%0d: got rw=%b rc=%b ra=%0d rd=%h cw=%b ci=%h ae=%b busy=%h, want rw=%b rc=%b ra=%0d rd=%h cw=%b ci=%h ae=%b busy=%h",
                   cyc, bus.reg_write, bus.reg_clear, bus.rd_addr, bus.rd_in, bus.car_write,
                   bus.car_in, bus.addr_err, bus.busy_mask,
                   e.rw, e.rc, e.ra, e.rd, e.cw, e.ci, e.ae, e.busy);
        end
      end
    end
  end

  initial begin
    set_idle();
    rst = 1'b1;
    step();
    check_zero("reset");
    step();
    rst = 1'b0;

    // Conflict right after reset: ALU first, then alternate.
    drive_a(1'b1, 4'd4, 8'h11, 1'b0, 1'b0, 8'h00);
    drive_m(1'b1, 4'd5, 8'h22);
    repeat (4) step();
    set_idle(); step();

    // Single ALU write
    drive_a(1'b1, 4'd3, 8'h5A, 1'b0, 1'b0, 8'h00);
    step();
    set_idle(); step(); step();

    // ALU clear
    drive_a(1'b1, 4'd6, 8'hEE, 1'b1, 1'b0, 8'h00);
    step();
    set_idle(); step();

    // Edge addresses: hard-zero with carry, then out of range load
    drive_a(1'b1, 4'd0, 8'h33, 1'b0, 1'b1, 8'h44);
    step();
    set_idle(); step();
    drive_m(1'b1, 4'd13, 8'h55);
    step();
    set_idle(); step(); step();

    // Scoreboard: reserve, reserve+release same cycle, release alone
    drive_res(1'b1, 4'd7);
    step();
    set_idle(); step();
    drive_res(1'b1, 4'd7);
    drive_m(1'b1, 4'd7, 8'h66);
    step();
    set_idle(); step();
    drive_m(1'b1, 4'd7, 8'h77);
    step();
    set_idle(); step();

    // Carry write releases the carry register
    drive_res(1'b1, 4'd12);
    step();
    set_idle(); step();
    drive_a(1'b1, 4'd2, 8'h09, 1'b0, 1'b1, 8'h01);
    step();
    set_idle(); step(); step();

    repeat (400) rand_cycle();

    // Asynchronous reset in the middle of a cycle with traffic in flight
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    set_idle();
    step();
    step();
    rst = 1'b0;

    repeat (400) rand_cycle();

    set_idle();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
